avalon_burst_arbiter: RTL and testbench

AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

---
 rtl/avalon_burst_arbiter.sv | 155 +++++++++++++++
 tb/tb_avalon_burst_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_arbiter.sv
// Two-requester Avalon-MM burst arbiter: round-robin grant, owner holds the host
// port from command acceptance until its last read/write beat completes.
module avalon_burst_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*ADDR_W-1:0]     m_address,
    input  logic [1:0]              m_read,
    input  logic [1:0]              m_write,
    input  logic [2*DATA_W-1:0]     m_writedata,
    input  logic [2*DATA_W/8-1:0]   m_byteenable,
    input  logic [2*BURST_W-1:0]    m_burstcount,
    output logic [1:0]              m_waitrequest,
    output logic [DATA_W-1:0]       m_readdata,
    output logic [1:0]              m_readdatavalid,
    output logic [ADDR_W-1:0]       h_address,
    output logic                    h_read,
    output logic                    h_write,
    output logic [DATA_W-1:0]       h_writedata,
    output logic [DATA_W/8-1:0]     h_byteenable,
    output logic [BURST_W-1:0]      h_burstcount,
    input  logic                    h_waitrequest,
    input  logic [DATA_W-1:0]       h_readdata,
    input  logic                    h_readdatavalid
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CMD      = 2'd1;
    localparam logic [1:0] RD_BURST = 2'd2;
    localparam logic [1:0] WR_BURST = 2'd3;

    logic [1:0]         state;
    logic               owner;
    logic               last_grant;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] burst_len;

    logic [1:0]         req;
    logic               grant_sel;
    logic [ADDR_W-1:0]  own_addr;
    logic               own_read;
    logic               own_write;
    logic [DATA_W-1:0]  own_wdata;
    logic [BE_W-1:0]    own_be;
    logic [BURST_W-1:0] own_bc;
    logic [BURST_W-1:0] eff_bc;
    logic [BURST_W-1:0] beat_inc;

    assign req = m_read | m_write;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (req == 2'b11) grant_sel = ~last_grant;
        else              grant_sel = req[1];
    end

    assign own_addr  = owner ? m_address[ADDR_W +: ADDR_W]       : m_address[0 +: ADDR_W];
    assign own_read  = owner ? m_read[1]                          : m_read[0];
    assign own_write = owner ? m_write[1]                         : m_write[0];
    assign own_wdata = owner ? m_writedata[DATA_W +: DATA_W]      : m_writedata[0 +: DATA_W];
    assign own_be    = owner ? m_byteenable[BE_W +: BE_W]         : m_byteenable[0 +: BE_W];
    assign own_bc    = owner ? m_burstcount[BURST_W +: BURST_W]   : m_burstcount[0 +: BURST_W];

    assign eff_bc     = (own_bc == '0) ? BURST_W'(1) : own_bc;
    assign beat_inc   = beat_cnt + BURST_W'(1);
    assign m_readdata = h_readdata;

    always_comb begin
        h_address       = '0;
        h_read          = 1'b0;
        h_write         = 1'b0;
        h_writedata     = '0;
        h_byteenable    = '0;
        h_burstcount    = '0;
        m_waitrequest   = 2'b11;
        m_readdatavalid = 2'b00;
        if (!reset) begin
            case (state)
                CMD: begin
                    h_address            = own_addr;
                    h_read               = own_read;
                    h_write              = own_write & ~own_read;
                    h_writedata          = own_wdata;
                    h_byteenable         = own_be;
                    h_burstcount         = own_bc;
                    m_waitrequest[owner] = h_waitrequest;
                end
                RD_BURST: begin
                    m_readdatavalid[owner] = h_readdatavalid;
                end
                WR_BURST: begin
                    h_address            = own_addr;
                    h_write              = own_write;
                    h_writedata          = own_wdata;
                    h_byteenable         = own_be;
                    h_burstcount         = own_bc;
                    m_waitrequest[owner] = h_waitrequest;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            burst_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= grant_sel;
                        beat_cnt <= '0;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    // Fairness only advances once the owner actually gets a command in.
                    if (!own_read && !own_write) begin
                        state <= IDLE;
                    end else if (h_read && !h_waitrequest) begin
                        burst_len  <= eff_bc;
                        last_grant <= owner;
                        state      <= RD_BURST;
                    end else if (h_write && !h_waitrequest) begin
                        burst_len  <= eff_bc;
                        last_grant <= owner;
                        beat_cnt   <= BURST_W'(1);
                        state      <= (eff_bc == BURST_W'(1)) ? IDLE : WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (h_readdatavalid) begin
                        beat_cnt <= beat_inc;
                        if (beat_inc == burst_len) state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (h_write && !h_waitrequest) begin
                        beat_cnt <= beat_inc;
                        if (beat_inc == burst_len) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed bench for avalon_burst_arbiter: read/write beats are checked against
// scoreboard queues filled as the host side is driven.
module tb_avalon_burst_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 5;
    localparam int BE_W    = DATA_W / 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [2*ADDR_W-1:0]    m_address = '0;
    logic [1:0]             m_read = '0;
    logic [1:0]             m_write = '0;
    logic [2*DATA_W-1:0]    m_writedata = '0;
    logic [2*BE_W-1:0]      m_byteenable = '0;
    logic [2*BURST_W-1:0]   m_burstcount = '0;
    logic [1:0]             m_waitrequest;
    logic [DATA_W-1:0]      m_readdata;
    logic [1:0]             m_readdatavalid;
    logic [ADDR_W-1:0]      h_address;
    logic                   h_read;
    logic                   h_write;
    logic [DATA_W-1:0]      h_writedata;
    logic [BE_W-1:0]        h_byteenable;
    logic [BURST_W-1:0]     h_burstcount;
    logic                   h_waitrequest = 1'b0;
    logic [DATA_W-1:0]      h_readdata = '0;
    logic                   h_readdatavalid = 1'b0;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [33:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [33:0] rd_e;
    logic [31:0] wr_e;

    avalon_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_byteenable(h_byteenable), .h_burstcount(h_burstcount),
        .h_waitrequest(h_waitrequest), .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read beats and accepted write beats are matched against the queues.
    always @(negedge clk) begin
        if (m_readdatavalid != 2'b00) begin
            if (rd_q.size() == 0) begin
                chk("rdv_unexpected", {62'd0, m_readdatavalid}, 64'd0);
            end else begin
                rd_e = rd_q.pop_front();
                chk("rdv_mask", {62'd0, m_readdatavalid}, {62'd0, rd_e[33:32]});
                chk("rd_data", {32'd0, m_readdata}, {32'd0, rd_e[31:0]});
            end
        end
        if (h_write && !h_waitrequest) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {63'd0, h_write}, 64'd0);
            end else begin
                wr_e = wr_q.pop_front();
                chk("wr_data", {32'd0, h_writedata}, {32'd0, wr_e});
            end
        end
    end

    // Entered at the start of an IDLE cycle with requests already driven.
    task automatic serve_read(input bit own, input int beats, input logic [31:0] addr,
                              input logic [4:0] bc, input logic [31:0] dbase);
        h_waitrequest   = 1'b0;
        h_readdatavalid = 1'b0;
        @(negedge clk);
        chk("idle_h_read", {63'd0, h_read}, 64'd0);
        chk("idle_wait", {62'd0, m_waitrequest}, 64'd3);
        tick();
        @(negedge clk);
        chk("cmd_h_read", {63'd0, h_read}, 64'd1);
        chk("cmd_addr", {32'd0, h_address}, {32'd0, addr});
        chk("cmd_bc", {59'd0, h_burstcount}, {59'd0, bc});
        chk("cmd_wait", {62'd0, m_waitrequest}, own ? 64'd1 : 64'd2);
        tick();
        for (int i = 0; i < beats; i++) begin
            h_readdatavalid = 1'b1;
            h_readdata      = dbase + i;
            rd_q.push_back({(own ? 2'b10 : 2'b01), dbase + i});
            @(negedge clk);
            chk("rd_h_read", {63'd0, h_read}, 64'd0);
            chk("rd_wait", {62'd0, m_waitrequest}, 64'd3);
            tick();
        end
        h_readdatavalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: host idle, both requesters stalled, stray beat blocked
        tick(); tick();
        h_readdatavalid = 1'b1;
        @(negedge clk);
        chk("rst_h_read", {63'd0, h_read}, 64'd0);
        chk("rst_h_write", {63'd0, h_write}, 64'd0);
        chk("rst_wait", {62'd0, m_waitrequest}, 64'd3);
        chk("rst_rdv", {62'd0, m_readdatavalid}, 64'd0);
        tick();
        reset = 1'b0;
        h_readdatavalid = 1'b0;

        // Stray beat in IDLE
        tick();
        h_readdatavalid = 1'b1;
        @(negedge clk);
        chk("stray_rdv", {62'd0, m_readdatavalid}, 64'd0);
        chk("stray_wait", {62'd0, m_waitrequest}, 64'd3);
        tick();
        h_readdatavalid = 1'b0;
        @(negedge clk);
        chk("stray_h_read", {63'd0, h_read}, 64'd0);
        tick();

        // Single 16-beat read from requester 0
        m_address    = {32'h0000_1100, 32'h0000_1000};
        m_burstcount = {5'd0, 5'd16};
        m_read       = 2'b01;
        serve_read(1'b0, 16, 32'h0000_1000, 5'd16, 32'hA000_0000);
        m_read          = 2'b00;
        h_readdatavalid = 1'b1;
        @(negedge clk);
        chk("post16_rdv", {62'd0, m_readdatavalid}, 64'd0);
        chk("post16_wait", {62'd0, m_waitrequest}, 64'd3);
        tick();
        h_readdatavalid = 1'b0;
        chk("post16_q", 64'(rd_q.size()), 64'd0);

        // Burstcount 0 from requester 1 means one beat
        m_burstcount = {5'd0, 5'd0};
        m_read       = 2'b10;
        serve_read(1'b1, 1, 32'h0000_1100, 5'd0, 32'hB000_0000);
        m_read          = 2'b00;
        h_readdatavalid = 1'b1;
        @(negedge clk);
        chk("bc0_extra_rdv", {62'd0, m_readdatavalid}, 64'd0);
        tick();
        h_readdatavalid = 1'b0;

        // Contention with burst 4 on both: grants alternate 0,1,0,1
        m_burstcount = {5'd4, 5'd4};
        m_read       = 2'b11;
        serve_read(1'b0, 4, 32'h0000_1000, 5'd4, 32'hC000_0000);
        serve_read(1'b1, 4, 32'h0000_1100, 5'd4, 32'hC100_0000);
        serve_read(1'b0, 4, 32'h0000_1000, 5'd4, 32'hC200_0000);
        serve_read(1'b1, 4, 32'h0000_1100, 5'd4, 32'hC300_0000);
        m_read = 2'b00;
        tick();
        chk("cont_q", 64'(rd_q.size()), 64'd0);

        // Write burst of 8 with host stalls on beats 3 and 5
        m_address    = {32'h0, 32'h0000_2000};
        m_burstcount = {5'd0, 5'd8};
        m_byteenable = {4'h0, 4'hA};
        m_writedata  = {32'h0, 32'hD000_0000};
        m_write      = 2'b01;
        @(negedge clk);
        chk("wr_idle_h_write", {63'd0, h_write}, 64'd0);
        tick();
        wr_q.push_back(32'hD000_0000);
        @(negedge clk);
        chk("wr_cmd_h_write", {63'd0, h_write}, 64'd1);
        chk("wr_cmd_be", {60'd0, h_byteenable}, 64'hA);
        chk("wr_cmd_wait", {62'd0, m_waitrequest}, 64'd2);
        tick();
        for (int b = 1; b < 8; b++) begin
            m_writedata[31:0] = 32'hD000_0000 + b;
            if (b == 2 || b == 4) begin
                h_waitrequest = 1'b1;
                @(negedge clk);
                chk("wr_stall_wait", {62'd0, m_waitrequest}, 64'd3);
                tick();
                h_waitrequest = 1'b0;
            end
            wr_q.push_back(32'hD000_0000 + b);
            @(negedge clk);
            chk("wr_beat_wait", {62'd0, m_waitrequest}, 64'd2);
            tick();
        end
        @(negedge clk);
        chk("wr_done_h_write", {63'd0, h_write}, 64'd0);
        chk("wr_done_wait", {62'd0, m_waitrequest}, 64'd3);
        chk("wr_count", 64'(wr_cnt), 64'd8);
        chk("wr_q", 64'(wr_q.size()), 64'd0);
        tick();
        // Owner withdraws in CMD: back to IDLE without a command
        m_write = 2'b00;
        @(negedge clk);
        chk("abort_cmd_wait", {62'd0, m_waitrequest}, 64'd2);
        chk("abort_h_write", {63'd0, h_write}, 64'd0);
        tick();
        @(negedge clk);
        chk("abort_idle_wait", {62'd0, m_waitrequest}, 64'd3);
        tick();

        // Reset at beat 5 of a 16-beat read from requester 0
        m_address    = {32'h0000_4100, 32'h0000_4000};
        m_burstcount = {5'd0, 5'd16};
        m_read       = 2'b01;
        @(negedge clk);
        chk("rr_idle_h_read", {63'd0, h_read}, 64'd0);
        tick();
        @(negedge clk);
        chk("rr_cmd_h_read", {63'd0, h_read}, 64'd1);
        tick();
        m_read = 2'b00;
        for (int i = 0; i < 4; i++) begin
            h_readdatavalid = 1'b1;
            h_readdata      = 32'hE000_0000 + i;
            rd_q.push_back({2'b01, 32'hE000_0000 + i});
            @(negedge clk);
            tick();
        end
        reset           = 1'b1;
        h_readdata      = 32'hE000_0004;
        @(negedge clk);
        chk("rr_rst_rdv", {62'd0, m_readdatavalid}, 64'd0);
        chk("rr_rst_wait", {62'd0, m_waitrequest}, 64'd3);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            h_readdatavalid = 1'b1;
            h_readdata      = 32'hE000_0005 + i;
            @(negedge clk);
            chk("rr_drop_rdv", {62'd0, m_readdatavalid}, 64'd0);
            chk("rr_drop_wait", {62'd0, m_waitrequest}, 64'd3);
            tick();
        end
        h_readdatavalid = 1'b0;
        chk("rr_q", 64'(rd_q.size()), 64'd0);
        // After reset requester 0 wins the tie
        m_burstcount = {5'd1, 5'd1};
        m_read       = 2'b11;
        serve_read(1'b0, 1, 32'h0000_4000, 5'd1, 32'hF000_0000);
        m_read = 2'b00;
        tick();
        tick();
        chk("final_rd_q", 64'(rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
